// File: rtl/pipeline_pkg.sv
// Shared pipeline encodings for the hazard controller.
// State enum, result-select load code and forward selects.
package pipeline_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam logic [1:0] RES_LOAD = 2'b01;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/forward_unit.sv
// Operand bypass select for one execute-stage source.
// Memory-stage producer beats writeback; x0 never forwards.
module forward_unit
  import pipeline_pkg::*;
(
  input  logic [4:0] rs_i,
  input  logic [4:0] rd_m_i,
  input  logic       we_m_i,
  input  logic [4:0] rd_w_i,
  input  logic       we_w_i,
  output logic [1:0] fwd_o
);

  // pick the youngest producer of rs_i
  always_comb begin
    fwd_o = FWD_RF;
    if (we_m_i && rd_m_i != 5'd0 && rd_m_i == rs_i)
      fwd_o = FWD_MEM;
    else if (we_w_i && rd_w_i != 5'd0 && rd_w_i == rs_i)
      fwd_o = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-miss stall FSM,
// load-use stall, branch flush and operand forwarding.
module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4:0]           rs1D,
  input  logic [4:0]           rs2D,
  input  logic [4:0]           rs1E,
  input  logic [4:0]           rs2E,
  input  logic [4:0]           RdE,
  input  logic                 RegWriteE,
  input  logic [1:0]           ResultSrcE,
  input  logic                 PCSrcE,
  input  logic [4:0]           RdM,
  input  logic [4:0]           RdW,
  input  logic                 RegWriteM,
  input  logic                 RegWriteW,
  input  logic                 mem_req_M,
  input  logic                 mem_ready,
  output logic                 StallPC,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 StallE,
  output logic                 StallM,
  output logic                 FlushF,
  output logic                 FlushD,
  output logic                 FlushM,
  output logic [1:0]           ForwardAE,
  output logic [1:0]           ForwardBE,
  output logic                 mem_err,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  localparam int WW = (MEM_TIMEOUT < 1) ? 1
                    : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] TO = WW'(MEM_TIMEOUT);

  // datapath width is reserved; only sanity-checked
  if (DATA_WIDTH < 1) begin : g_dw_chk
    $error("DATA_WIDTH must be positive");
  end

  state_e               state_q, state_d;
  logic [WW-1:0]        wait_q, wait_d;
  logic                 err_q, err_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 mem_stall;
  logic                 load_use;

  // RegWriteE does not qualify load-use: a load always writes
  logic unused_ok;
  assign unused_ok = RegWriteE;

  assign load_use = (ResultSrcE == RES_LOAD) &&
                    (RdE != 5'd0) &&
                    (RdE == rs1D || RdE == rs2D);

  // next state, wait counter, sticky error
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    err_d     = err_q;
    mem_stall = 1'b0;
    unique case (state_q)
      RUN: begin
        wait_d = '0;
        if (mem_req_M && !mem_ready) begin
          state_d   = MEM_WAIT;
          mem_stall = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready || wait_q == TO) begin
          state_d = RUN;
          wait_d  = '0;
          if (!mem_ready) err_d = 1'b1;
        end else begin
          wait_d    = wait_q + WW'(1);
          mem_stall = 1'b1;
        end
      end
    endcase
  end

  // stall/flush outputs: miss > branch > load-use
  always_comb begin
    StallPC = 1'b0;
    StallF  = 1'b0;
    StallD  = 1'b0;
    StallE  = 1'b0;
    StallM  = 1'b0;
    FlushF  = 1'b0;
    FlushD  = 1'b0;
    FlushM  = 1'b0;
    if (!rst_n) begin
      StallPC = 1'b0;
    end else if (mem_stall) begin
      StallPC = 1'b1;
      StallF  = 1'b1;
      StallD  = 1'b1;
      StallE  = 1'b1;
      StallM  = 1'b1;
      FlushM  = 1'b1;
    end else if (PCSrcE) begin
      FlushF  = 1'b1;
      FlushD  = 1'b1;
    end else if (load_use) begin
      StallPC = 1'b1;
      StallF  = 1'b1;
      FlushD  = 1'b1;
    end
  end

  // saturating stall-cycle counter
  always_comb begin
    cnt_d = cnt_q;
    if (StallPC && cnt_q != '1)
      cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  // state, counters and error flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_err   = err_q;
  assign stall_cnt = cnt_q;

  forward_unit u_fwd_a (
    .rs_i   (rs1E),
    .rd_m_i (RdM),
    .we_m_i (RegWriteM),
    .rd_w_i (RdW),
    .we_w_i (RegWriteW),
    .fwd_o  (ForwardAE)
  );

  forward_unit u_fwd_b (
    .rs_i   (rs2E),
    .rd_m_i (RdM),
    .we_m_i (RegWriteM),
    .rd_w_i (RdW),
    .we_w_i (RegWriteW),
    .fwd_o  (ForwardBE)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomised bench for hazard_ctrl against a cycle-count
// reference model, plus directed hazard scenarios.
module tb_hazard_ctrl;

  localparam int TO  = 8;
  localparam int CW  = 6;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, RdE, RdM, RdW;
  logic RegWriteE, PCSrcE, RegWriteM, RegWriteW;
  logic [1:0] ResultSrcE;
  logic mem_req_M, mem_ready;
  logic StallPC, StallF, StallD, StallE, StallM;
  logic FlushF, FlushD, FlushM;
  logic [1:0] ForwardAE, ForwardBE;
  logic mem_err;
  logic [CW-1:0] stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model: waiting flag, cycles waited, error, stall count
  bit m_wait;
  int m_cnt;
  bit m_err;
  int m_scnt;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .DATA_WIDTH  (32),
    .MEM_TIMEOUT (TO),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rs1D       (rs1D),
    .rs2D       (rs2D),
    .rs1E       (rs1E),
    .rs2E       (rs2E),
    .RdE        (RdE),
    .RegWriteE  (RegWriteE),
    .ResultSrcE (ResultSrcE),
    .PCSrcE     (PCSrcE),
    .RdM        (RdM),
    .RdW        (RdW),
    .RegWriteM  (RegWriteM),
    .RegWriteW  (RegWriteW),
    .mem_req_M  (mem_req_M),
    .mem_ready  (mem_ready),
    .StallPC    (StallPC),
    .StallF     (StallF),
    .StallD     (StallD),
    .StallE     (StallE),
    .StallM     (StallM),
    .FlushF     (FlushF),
    .FlushD     (FlushD),
    .FlushM     (FlushM),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE),
    .mem_err    (mem_err),
    .stall_cnt  (stall_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] fwd_ref(input int rs, input int rdm,
                                         input bit wm, input int rdw,
                                         input bit ww);
    if (wm && rdm != 0 && rdm == rs) return 2'd2;
    if (ww && rdw != 0 && rdw == rs) return 2'd1;
    return 2'd0;
  endfunction

  task automatic idle();
    rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; RdE = 0;
    RdM = 0; RdW = 0; RegWriteE = 0; RegWriteM = 0;
    RegWriteW = 0; ResultSrcE = 0; PCSrcE = 0;
    mem_req_M = 0; mem_ready = 0;
  endtask

  // check combinational outputs, clock once, advance the model
  task automatic cyc();
    bit hold, exitw, lu;
    logic [7:0] exp_v, got_v;
    #2;
    hold  = 0;
    exitw = 0;
    if (m_wait) begin
      if (mem_ready || m_cnt >= TO) exitw = 1;
      else hold = 1;
    end else begin
      hold = mem_req_M && !mem_ready;
    end
    lu = (ResultSrcE == 2'b01) && RdE != 0 &&
         (RdE == rs1D || RdE == rs2D);
    if (!rst_n)      exp_v = 8'b0000_0000;
    else if (hold)   exp_v = 8'b1111_1001;
    else if (PCSrcE) exp_v = 8'b0000_0110;
    else if (lu)     exp_v = 8'b1100_0010;
    else             exp_v = 8'b0000_0000;
    got_v = {StallPC, StallF, StallD, StallE, StallM,
             FlushF, FlushD, FlushM};
    chk("stall_flush", 32'(got_v), 32'(exp_v));
    chk("fwdA", 32'(ForwardAE),
        32'(fwd_ref(rs1E, RdM, RegWriteM, RdW, RegWriteW)));
    chk("fwdB", 32'(ForwardBE),
        32'(fwd_ref(rs2E, RdM, RegWriteM, RdW, RegWriteW)));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
    chk("mem_err", 32'(mem_err), 32'(m_err));
    @(posedge clk);
    if (!rst_n) begin
      m_wait = 0; m_cnt = 0; m_err = 0; m_scnt = 0;
    end else begin
      if (exp_v[7] && m_scnt < SAT) m_scnt++;
      if (m_wait) begin
        if (exitw) begin
          m_wait = 0;
          m_cnt  = 0;
          if (!mem_ready) m_err = 1;
        end else begin
          m_cnt++;
        end
      end else if (hold) begin
        m_wait = 1;
        m_cnt  = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    cyc();
    cyc();
    rst_n = 1;
  endtask

  initial begin
    int nst;
    int rdy_pct;
    idle();
    m_wait = 0; m_cnt = 0; m_err = 0; m_scnt = 0;
    #1;
    do_reset();
    chk("rst_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_err", 32'(mem_err), 32'd0);

    // load-use: single stall cycle
    ResultSrcE = 2'b01; RdE = 5; rs1D = 5;
    cyc();
    idle();
    cyc();
    chk("lu_cnt", 32'(stall_cnt), 32'd1);

    // forward priority M over W, then W alone
    RdM = 3; RdW = 3; rs1E = 3; RegWriteM = 1; RegWriteW = 1;
    #1 chk("fwd_m", 32'(ForwardAE), 32'd2);
    cyc();
    RdM = 0;
    #1 chk("fwd_w", 32'(ForwardAE), 32'd1);
    cyc();
    idle();

    // 4-cycle miss then ready
    do_reset();
    mem_req_M = 1;
    repeat (4) cyc();
    mem_ready = 1;
    #1 chk("miss_exit", 32'(StallPC | FlushM), 32'd0);
    cyc();
    idle();
    chk("miss_cnt", 32'(stall_cnt), 32'd4);

    // branch held through miss: flush only on exit
    PCSrcE = 1; mem_req_M = 1;
    #1 chk("br_wait", 32'(FlushF), 32'd0);
    repeat (3) cyc();
    mem_ready = 1;
    #1 chk("br_exit", 32'(FlushF & FlushD), 32'd1);
    cyc();
    idle();

    // timeout: 8 stalled wait cycles after entry
    mem_req_M = 1;
    cyc();
    mem_req_M = 0;
    nst = 0;
    for (int i = 0; i < 12; i++) begin
      #1 if (StallPC) nst++;
      cyc();
    end
    chk("to_waits", 32'(nst), 32'd8);
    chk("to_err", 32'(mem_err), 32'd1);
    cyc();
    chk("to_sticky", 32'(mem_err), 32'd1);

    // reset mid-wait
    mem_req_M = 1;
    repeat (3) cyc();
    mem_req_M = 0;
    rst_n = 0;
    cyc();
    rst_n = 1;
    #1 chk("rw_stall", 32'(StallPC), 32'd0);
    chk("rw_cnt", 32'(stall_cnt), 32'd0);
    chk("rw_err", 32'(mem_err), 32'd0);
    cyc();

    // randomised traffic
    rdy_pct = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0)
        rdy_pct = ($urandom_range(0, 2) == 0) ? 3 : 50;
      rst_n      = ($urandom_range(0, 199) != 0);
      rs1D       = 5'($urandom_range(0, 3));
      rs2D       = 5'($urandom_range(0, 3));
      rs1E       = 5'($urandom_range(0, 3));
      rs2E       = 5'($urandom_range(0, 3));
      RdE        = 5'($urandom_range(0, 3));
      RdM        = 5'($urandom_range(0, 3));
      RdW        = 5'($urandom_range(0, 3));
      RegWriteE  = 1'($urandom);
      RegWriteM  = 1'($urandom);
      RegWriteW  = 1'($urandom);
      ResultSrcE = 2'($urandom);
      PCSrcE     = ($urandom_range(0, 5) == 0);
      mem_req_M  = ($urandom_range(0, 3) == 0);
      mem_ready  = ($urandom_range(0, 99) < rdy_pct);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
